// File: rtl/vga_dither_output_pkg.sv
// Shared constants for the VGA dither back-end: image size, dither modes,
// region encoding and the 4x4 Bayer threshold matrix.
package vga_dither_output_pkg;

    localparam int IMG_DIM = 128;

    localparam logic [1:0] MODE_THRESH   = 2'd0;
    localparam logic [1:0] MODE_BAYER    = 2'd1;
    localparam logic [1:0] MODE_TEMPORAL = 2'd2;

    typedef enum logic [1:0] {
        REG_OTHER = 2'd0,
        REG_LEFT  = 2'd1,
        REG_RIGHT = 2'd2
    } region_t;

    // Nibble i holds B4[y][x] with i = 4*y + x.
    localparam logic [63:0] BAYER4 = 64'h5D7F_91B3_6E4C_A280;

    function automatic logic [3:0] bayer_m(input logic [1:0] x, input logic [1:0] y);
        logic [5:0] idx;
        idx = {y, x, 2'b00};
        return BAYER4[idx +: 4];
    endfunction

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return (m == MODE_TEMPORAL) ? MODE_THRESH : m + 2'd1;
    endfunction

endpackage

// File: rtl/vga_dither_output_if.sv
// Signal bundle between the VGA controller / image BRAMs and the dither back-end.
interface vga_dither_output_if #(
    parameter int AW = 14
);
    logic [10:0]   hcount;
    logic [10:0]   vcount;
    logic          blank;
    logic          hs_in;
    logic          vs_in;
    logic          show_in;
    logic          show_out;
    logic          mode_step;
    logic [AW-1:0] addr_in;
    logic [7:0]    pix_in;
    logic [AW-1:0] addr_out;
    logic [7:0]    pix_out;
    logic          hs;
    logic          vs;
    logic          R;
    logic          G;
    logic          B;
    logic [1:0]    mode;

    modport master (
        output hcount, vcount, blank, hs_in, vs_in, show_in, show_out, mode_step,
        output pix_in, pix_out,
        input  addr_in, addr_out, hs, vs, R, G, B, mode
    );

    modport slave (
        input  hcount, vcount, blank, hs_in, vs_in, show_in, show_out, mode_step,
        input  pix_in, pix_out,
        output addr_in, addr_out, hs, vs, R, G, B, mode
    );
endinterface

// File: rtl/vga_dither_output_dither_cell.sv
// Combinational 8-bit to 1-bit conversion: MSB threshold or Bayer ordered dither.
module dither_cell
    import vga_dither_output_pkg::*;
(
    input  logic [7:0] i_p,
    input  logic [1:0] i_x,
    input  logic [1:0] i_y,
    input  logic [1:0] i_mode,
    output logic       o_bit
);
    logic [3:0] w_m;
    logic [8:0] w_t;
    logic       w_ge;

    assign w_m  = bayer_m(i_x, i_y);
    // 16*M + 8 tops out at 248, so the 9-bit compare never overflows.
    assign w_t  = {1'b0, w_m, 4'b1000};
    assign w_ge = ({1'b0, i_p} >= w_t);

    always_comb begin
        o_bit = i_p[7];
        case (i_mode)
            MODE_BAYER, MODE_TEMPORAL: o_bit = w_ge;
            default:                   o_bit = i_p[7];
        endcase
    end
endmodule

// File: rtl/vga_dither_output.sv
// Display back-end: BRAM addressing, 2-stage pixel/sync pipeline and
// per-frame dither mode switching for the left (input) and right (output) images.
module vga_dither_output #(
    parameter int IMG_DIM = vga_dither_output_pkg::IMG_DIM,
    parameter int AW      = 14
) (
    input  logic               clk,
    input  logic               rst,
    vga_dither_output_if.slave bus
);
    import vga_dither_output_pkg::*;

    localparam int          LOG  = $clog2(IMG_DIM);
    localparam logic [10:0] LIM  = 11'(IMG_DIM);
    localparam logic [10:0] LIM2 = 11'(2 * IMG_DIM);

    logic        w_v_in;
    logic        w_left;
    logic        w_right;
    region_t     w_region;
    logic        w_frame_start;
    logic [1:0]  w_pending_next;
    logic [1:0]  w_x;
    logic        w_bit_in;
    logic        w_bit_out;
    logic [2:0]  w_rgb_next;

    region_t     r_region;
    logic        r_blank;
    logic        r_show_in;
    logic        r_show_out;
    logic [1:0]  r_hlo;
    logic [1:0]  r_vlo;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_hs;
    logic        r_vs;
    logic [2:0]  r_rgb;
    logic [10:0] r_vcount_prev;
    logic [1:0]  r_frame_cnt;
    logic [1:0]  r_mode;
    logic [1:0]  r_pending;

    assign w_v_in  = (bus.vcount < LIM);
    assign w_left  = w_v_in && (bus.hcount < LIM);
    assign w_right = w_v_in && (bus.hcount >= LIM) && (bus.hcount < LIM2);

    always_comb begin
        w_region = REG_OTHER;
        if (w_left)
            w_region = REG_LEFT;
        else if (w_right)
            w_region = REG_RIGHT;
    end

    assign bus.addr_in  = w_left  ? {bus.vcount[LOG-1:0], bus.hcount[LOG-1:0]} : '0;
    assign bus.addr_out = w_right ? {bus.vcount[LOG-1:0], bus.hcount[LOG-1:0]} : '0;

    assign w_frame_start  = (bus.vcount == 11'd0) && (r_vcount_prev != 11'd0);
    // A step landing on frame_start is folded in before the mode is loaded.
    assign w_pending_next = bus.mode_step ? next_mode(r_pending) : r_pending;

    assign w_x = (r_mode == MODE_TEMPORAL) ? (r_hlo + r_frame_cnt) : r_hlo;

    dither_cell u_cell_in (
        .i_p    (bus.pix_in),
        .i_x    (w_x),
        .i_y    (r_vlo),
        .i_mode (r_mode),
        .o_bit  (w_bit_in)
    );

    dither_cell u_cell_out (
        .i_p    (bus.pix_out),
        .i_x    (w_x),
        .i_y    (r_vlo),
        .i_mode (r_mode),
        .o_bit  (w_bit_out)
    );

    always_comb begin
        w_rgb_next = 3'b111;
        if (r_blank)
            w_rgb_next = 3'b000;
        else if (r_region == REG_LEFT && r_show_in)
            w_rgb_next = {3{w_bit_in}};
        else if (r_region == REG_RIGHT && r_show_out)
            w_rgb_next = {3{w_bit_out}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_region      <= REG_OTHER;
            r_blank       <= 1'b0;
            r_show_in     <= 1'b0;
            r_show_out    <= 1'b0;
            r_hlo         <= 2'd0;
            r_vlo         <= 2'd0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_rgb         <= 3'b000;
            r_vcount_prev <= 11'd0;
            r_frame_cnt   <= 2'd0;
            r_mode        <= MODE_THRESH;
            r_pending     <= MODE_THRESH;
        end else begin
            r_region      <= w_region;
            r_blank       <= bus.blank;
            r_show_in     <= bus.show_in;
            r_show_out    <= bus.show_out;
            r_hlo         <= bus.hcount[1:0];
            r_vlo         <= bus.vcount[1:0];
            r_hs1         <= bus.hs_in;
            r_vs1         <= bus.vs_in;
            r_hs          <= r_hs1;
            r_vs          <= r_vs1;
            r_rgb         <= w_rgb_next;
            r_vcount_prev <= bus.vcount;
            r_pending     <= w_pending_next;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 2'd1;
                r_mode      <= w_pending_next;
            end
        end
    end

    assign bus.hs   = r_hs;
    assign bus.vs   = r_vs;
    assign bus.R    = r_rgb[2];
    assign bus.G    = r_rgb[1];
    assign bus.B    = r_rgb[0];
    assign bus.mode = r_mode;
endmodule

// File: tb/tb_vga_dither_output.sv
// Directed bench for vga_dither_output with a 1-cycle-latency BRAM model.
module tb_vga_dither_output;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] mem_in  [0:16383];
    logic [7:0] mem_out [0:16383];

    vga_dither_output_if #(.AW(14)) bus();

    vga_dither_output #(.IMG_DIM(128), .AW(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.pix_in  <= mem_in[bus.addr_in];
        bus.pix_out <= mem_out[bus.addr_out];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {29'd0, bus.R, bus.G, bus.B};
    endfunction

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem_in[i]  = 8'h00;
            mem_out[i] = 8'h00;
        end
        mem_in[14'h185]  = 8'h80;
        mem_in[14'h186]  = 8'h7F;
        mem_in[14'h1FF]  = 8'hFF;
        mem_in[14'h000]  = 8'hFF;
        mem_out[14'h180] = 8'h00;
        mem_out[14'h080] = 8'd200;
        mem_out[14'h081] = 8'd72;
        mem_out[14'h084] = 8'd199;
        mem_in[14'h003]  = 8'd8;
        mem_in[14'h007]  = 8'd7;
        mem_in[14'h004]  = 8'd135;

        bus.hcount = 11'd0; bus.vcount = 11'd0; bus.blank = 1'b0;
        bus.hs_in = 1'b0; bus.vs_in = 1'b0;
        bus.show_in = 1'b1; bus.show_out = 1'b1; bus.mode_step = 1'b0;
        bus.pix_in = 8'h00; bus.pix_out = 8'h00;

        // Reset state, sync registers held high even with sync inputs low
        tick(); tick();
        chk("reset_rgb",  rgb(), 32'h0);
        chk("reset_hs",   {31'd0, bus.hs}, 32'h1);
        chk("reset_vs",   {31'd0, bus.vs}, 32'h1);
        chk("reset_mode", {30'd0, bus.mode}, 32'h0);

        // Sync delay of exactly two cycles, OTHER region is white
        rst = 1'b0; bus.vcount = 11'd200; bus.hcount = 11'd300; bus.vs_in = 1'b1;
        tick();
        chk("hs_d1_still_high", {31'd0, bus.hs}, 32'h1);
        tick();
        chk("hs_d2_low",   {31'd0, bus.hs}, 32'h0);
        chk("vs_d2_high",  {31'd0, bus.vs}, 32'h1);
        chk("other_white", rgb(), 32'h7);
        bus.hs_in = 1'b1;
        tick();
        chk("hs_rise_d1", {31'd0, bus.hs}, 32'h0);
        tick();
        chk("hs_rise_d2", {31'd0, bus.hs}, 32'h1);

        // Mode 0 threshold on the left image
        bus.vcount = 11'd3; bus.hcount = 11'd5;
        #1;
        chk("addr_in_185",   {18'd0, bus.addr_in}, 32'h185);
        chk("addr_out_left", {18'd0, bus.addr_out}, 32'h0);
        tick(); tick();
        chk("thresh_80", rgb(), 32'h7);
        bus.hcount = 11'd6;
        tick(); tick();
        chk("thresh_7f", rgb(), 32'h0);

        // hcount 127 -> 128 crosses into RIGHT without stale pixels
        bus.hcount = 11'd127;
        tick();
        bus.hcount = 11'd128;
        #1;
        chk("addr_out_180", {18'd0, bus.addr_out}, 32'h180);
        chk("addr_in_right", {18'd0, bus.addr_in}, 32'h0);
        tick();
        chk("h127_left_ff", rgb(), 32'h7);
        tick();
        chk("h128_right_00", rgb(), 32'h0);

        // Four steps mid-frame: mode waits for frame start, then lands on 1
        for (int i = 0; i < 4; i++) begin
            bus.mode_step = 1'b1; tick();
            bus.mode_step = 1'b0; tick();
        end
        chk("mode_held_midframe", {30'd0, bus.mode}, 32'h0);
        bus.vcount = 11'd0;
        tick();
        chk("mode_after_fs", {30'd0, bus.mode}, 32'h1);

        // Mode 1 Bayer on the right image, row 1
        bus.vcount = 11'd1; bus.hcount = 11'd128;
        tick();
        bus.hcount = 11'd129;
        tick();
        chk("bayer_200_T200", rgb(), 32'h7);
        bus.hcount = 11'd132;
        tick();
        chk("bayer_72_T72", rgb(), 32'h7);
        tick();
        chk("bayer_199_T200", rgb(), 32'h0);
        bus.show_out = 1'b0;
        tick(); tick();
        chk("show_out_off_white", rgb(), 32'h7);
        bus.show_out = 1'b1;

        // Mode 2 with frame_cnt ending at 1 after four more frame starts
        bus.mode_step = 1'b1; tick();
        bus.mode_step = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            bus.vcount = 11'd5; tick();
            bus.vcount = 11'd0; tick();
        end
        chk("mode_temporal", {30'd0, bus.mode}, 32'h2);
        bus.hcount = 11'd3;
        tick();
        bus.hcount = 11'd7;
        tick();
        bus.hcount = 11'd4;
        chk("temporal_h3_p8", rgb(), 32'h7);
        tick();
        chk("temporal_h7_p7", rgb(), 32'h0);
        tick();
        chk("temporal_h4_p135", rgb(), 32'h0);

        // Step coincident with frame start is applied to the new frame
        bus.vcount = 11'd5; tick();
        bus.vcount = 11'd0; bus.mode_step = 1'b1; tick();
        bus.mode_step = 1'b0;
        chk("step_on_fs", {30'd0, bus.mode}, 32'h0);

        // Blank on the left region with a full-scale pixel
        bus.vcount = 11'd3; bus.hcount = 11'd127; bus.blank = 1'b1;
        tick(); tick();
        chk("blank_black", rgb(), 32'h0);

        // show_in toggled mid-line follows the same 2-cycle latency
        bus.blank = 1'b0; bus.hcount = 11'd6; bus.show_in = 1'b0;
        tick(); tick();
        chk("show_in_off_white", rgb(), 32'h7);
        bus.show_in = 1'b1;
        tick();
        chk("show_in_on_d1", rgb(), 32'h7);
        tick();
        chk("show_in_on_d2", rgb(), 32'h0);

        // Reset mid-frame reverts mode and pending mode
        bus.mode_step = 1'b1; tick();
        bus.mode_step = 1'b0;
        bus.vcount = 11'd5; tick();
        bus.vcount = 11'd0; tick();
        chk("mode_before_rst", {30'd0, bus.mode}, 32'h1);
        rst = 1'b1; bus.hs_in = 1'b0; bus.vcount = 11'd3;
        tick();
        chk("rst_mid_mode", {30'd0, bus.mode}, 32'h0);
        chk("rst_mid_rgb",  rgb(), 32'h0);
        chk("rst_mid_hs",   {31'd0, bus.hs}, 32'h1);
        rst = 1'b0; bus.hs_in = 1'b1;
        bus.vcount = 11'd5; tick();
        bus.vcount = 11'd0; tick();
        chk("pending_cleared", {30'd0, bus.mode}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
